ps2_scan_ctrl: RTL and testbench
================================

// Module: ps2_scan_ctrl
// PURPOSE
//  Sequences the raw byte stream from the PS/2 keyboard receiver into key events.
//  Resolves E0 (extended), F0 (break) and E1 (Pause) prefixes, tracks modifier/caps state,
//  filters keyboard status codes, and buffers events in a FIFO for the LCD writer.
//  Sits between the PS/2 receiver (byte strobe) and the LCD/character-mapping logic.
// PARAMETERS
//  FIFO_DEPTH      8      event FIFO entries; power of two, 2..64
//  PREFIX_TIMEOUT  50000  clk cycles allowed between prefix byte and next byte (1 ms @ 50 MHz)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  byte_valid  in   1   one-cycle strobe: byte_data holds a new received scan byte
//  byte_data   in   8   received scan byte
//  evt_rd      in   1   pop the head event; ignored when evt_valid=0
//  evt_valid   out  1   FIFO not empty; evt_data valid (first-word-fall-through)
//  evt_data    out  10  {ext, brk, code[7:0]} of head event
//  mods        out  4   {caps_lock, alt, ctrl, shift}, live state
//  ovf         out  1   sticky: an event was dropped on full FIFO
//  ovf_clr     in   1   clears ovf (set wins if drop and clear in the same cycle)
//  err_cnt     out  8   saturating count of status/error bytes received
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: state=IDLE, FIFO empty, evt_valid=0, evt_data=0, mods=0, ovf=0, err_cnt=0, timers=0.
//  FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (after E1).
//   IDLE: E0->EXT; F0->BRK; E1->PAUSE with skip_cnt=7; other code->push {0,0,code}.
//   EXT: F0->EXT_BRK; other code->push {1,0,code}, ->IDLE.
//   BRK: code->push {0,1,code}, ->IDLE.   EXT_BRK: code->push {1,1,code}, ->IDLE.
//   PAUSE: each byte decrements skip_cnt; on the 7th byte push {1,0,8'hE1}, ->IDLE.
//  Status bytes 00, AA, EE, FA, FC, FE, FF: never pushed, err_cnt+1 (saturates at 255),
//   FSM -> IDLE from any state (aborts a partial prefix or Pause sequence).
//  Timeout: in EXT/BRK/EXT_BRK/PAUSE, a counter increments each cycle, clears on byte_valid;
//   on reaching PREFIX_TIMEOUT-1 with no byte -> IDLE, nothing pushed. Counter held 0 in IDLE.
//  Latency: the byte_valid cycle that completes an event (N) -> evt_valid/evt_data at N+1.
//  Modifiers (updated on the completing byte, regardless of FIFO space):
//   shift = L(12) | R(59) held; ctrl = 14 or E0 14 held; alt = 11 or E0 11 held.
//   caps_lock toggles on a make of 58 only if 58 is not already held (typematic repeats
//   do not toggle); the break of 58 clears held.
//  FIFO: push when an event completes; pop on evt_rd & evt_valid.
//   Full & push & no pop: event dropped, ovf<=1. Full & push & pop: both succeed, count unchanged.
//   Empty & push & evt_rd: pop ignored, event stored. Pointers wrap modulo FIFO_DEPTH.
//  Reset asserted mid-sequence: all state cleared immediately; queued events are lost.
// STRUCTURE
//  ps2_pkg: state encoding, scan constants (E0, F0, E1, 12, 59, 14, 11, 58),
//   status-code list, event field widths/offsets.
//  Sub-module ps2_evt_fifo: synchronous FWFT FIFO (width 10, FIFO_DEPTH), with full/empty
//   and same-cycle push/pop rules above; instantiated once.
// TESTING
//  1C -> evt {0,0,1C} at N+1; F0 1C -> {0,1,1C}; exactly one event per sequence.
//  E0 75, E0 F0 75 -> {1,0,75}, {1,1,75}; E1 14 77 E1 F0 14 F0 77 -> single {1,0,E1}.
//  12 then 1C then F0 12 -> mods.shift 1 then 0; 58,58,F0 58 -> caps=1 (repeat no toggle).
//  E0 then idle PREFIX_TIMEOUT cycles then 1C -> only {0,0,1C}; E0 AA -> no event, err_cnt=1.
//  Push 9 events with no pops (depth 8) -> 8 stored in order, ovf=1; ovf_clr -> ovf=0.
//  Full FIFO, push+pop same cycle -> count stays 8, order kept; rst mid-E0 -> all outputs reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code sequencer: FSM states, scan constants,
// event field layout and the keyboard status-code classifier.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Bytes following E1 before the Pause event is emitted.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int EVT_CODE_W  = 8;
  localparam int EVT_BRK_BIT = 8;
  localparam int EVT_EXT_BIT = 9;
  localparam int EVT_W       = 10;

  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted only when
// the same cycle also pops, otherwise it is dropped and flagged.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = EVT_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & full & ~do_pop;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read port is masked to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Turns raw PS/2 scan bytes into {ext, brk, code} key events, tracking modifier and
// caps-lock state, counting keyboard status bytes and queueing events for the LCD side.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       evt_rd,
  output logic       evt_valid,
  output logic [9:0] evt_data,
  output logic [3:0] mods,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic [7:0] err_cnt
);

  localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(PREFIX_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d;
  logic          lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic          lalt_q, lalt_d, ralt_q, ralt_d;
  logic          caps_q, caps_d, caps_held_q, caps_held_d;

  logic          evt_push, evt_ext, evt_brk;
  logic [7:0]    evt_code;
  logic          fifo_empty, fifo_full, fifo_dropped;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    evt_push = 1'b0;
    evt_ext  = 1'b0;
    evt_brk  = 1'b0;
    evt_code = byte_data;
    if (byte_valid) begin
      tmr_d = '0;
      if (is_status(byte_data)) begin
        state_d = ST_IDLE;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byte_data == SC_EXT)        state_d = ST_EXT;
            else if (byte_data == SC_BRK)   state_d = ST_BRK;
            else if (byte_data == SC_PAUSE) begin
              state_d = ST_PAUSE;
              skip_d  = PAUSE_SKIP;
            end else evt_push = 1'b1;
          end
          ST_EXT: begin
            if (byte_data == SC_BRK) state_d = ST_EXT_BRK;
            else begin
              evt_push = 1'b1;
              evt_ext  = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_BRK: begin
            evt_push = 1'b1;
            evt_brk  = 1'b1;
            state_d  = ST_IDLE;
          end
          ST_EXT_BRK: begin
            evt_push = 1'b1;
            evt_ext  = 1'b1;
            evt_brk  = 1'b1;
            state_d  = ST_IDLE;
          end
          ST_PAUSE: begin
            // The whole Pause make sequence collapses into one extended E1 event.
            if (skip_q == 3'd1) begin
              evt_push = 1'b1;
              evt_ext  = 1'b1;
              evt_code = SC_PAUSE;
              skip_d   = '0;
              state_d  = ST_IDLE;
            end else skip_d = skip_q - 3'd1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (tmr_q == TMR_LAST) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else tmr_d = tmr_q + TW'(1);
    end
  end

  // E0 12 / E0 59 are fake shifts emitted around some extended keys, so only plain codes count.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (evt_push) begin
      if (!evt_ext && evt_code == SC_LSHIFT) lshift_d = ~evt_brk;
      if (!evt_ext && evt_code == SC_RSHIFT) rshift_d = ~evt_brk;
      if (evt_code == SC_CTRL) begin
        if (evt_ext) rctrl_d = ~evt_brk;
        else         lctrl_d = ~evt_brk;
      end
      if (evt_code == SC_ALT) begin
        if (evt_ext) ralt_d = ~evt_brk;
        else         lalt_d = ~evt_brk;
      end
      if (!evt_ext && evt_code == SC_CAPS) begin
        if (evt_brk) caps_held_d = 1'b0;
        else begin
          if (!caps_held_q) caps_d = ~caps_q;
          caps_held_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)      ovf_d = 1'b0;
    if (fifo_dropped) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      tmr_q       <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (evt_push),
    .wr_data ({evt_ext, evt_brk, evt_code}),
    .pop     (evt_rd),
    .rd_data (evt_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .dropped (fifo_dropped)
  );

  assign evt_valid = ~fifo_empty;
  assign mods      = {caps_q, lalt_q | ralt_q, lctrl_q | rctrl_q, lshift_q | rshift_q};
  assign ovf       = ovf_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl: prefix decoding, Pause, modifiers, status filtering,
// prefix timeout, FIFO overflow / same-cycle push+pop and asynchronous reset.
module tb_ps2_scan_ctrl;

  localparam int DEPTH = 8;
  localparam int PT    = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       evt_rd;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic [3:0] mods;
  logic       ovf;
  logic       ovf_clr;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] codes [9];

  always #5 clk = ~clk;

  ps2_scan_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (PT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .evt_rd     (evt_rd),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .mods       (mods),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .err_cnt    (err_cnt)
  );

  // Every stimulus task starts and ends on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_pop();
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 2 * DEPTH && evt_valid; i++) do_pop();
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; evt_rd = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", evt_valid); end
    total++; if (evt_data !== 10'h000) begin bad++; $display("[TB] FAIL reset_data got=%h exp=000", evt_data); end
    total++; if (mods !== 4'h0) begin bad++; $display("[TB] FAIL reset_mods got=%h exp=0", mods); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_err got=%h exp=00", err_cnt); end
  endtask

  task automatic test_make_break();
    send_byte(8'h1C);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("[TB] FAIL make_valid got=%b exp=1", evt_valid); end
    total++; if (evt_data !== 10'h01C) begin bad++; $display("[TB] FAIL make_data got=%h exp=01C", evt_data); end
    do_pop();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL make_single got=%b exp=0", evt_valid); end
    send_byte(8'hF0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL brk_prefix got=%b exp=0", evt_valid); end
    send_byte(8'h1C);
    total++; if (evt_data !== 10'h11C) begin bad++; $display("[TB] FAIL brk_data got=%h exp=11C", evt_data); end
    do_pop();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL brk_single got=%b exp=0", evt_valid); end
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75);
    total++; if (evt_data !== 10'h275) begin bad++; $display("[TB] FAIL ext_make got=%h exp=275", evt_data); end
    do_pop();
    send_byte(8'hE0); send_byte(8'hF0);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ext_brk_prefix got=%b exp=0", evt_valid); end
    send_byte(8'h75);
    total++; if (evt_data !== 10'h375) begin bad++; $display("[TB] FAIL ext_brk got=%h exp=375", evt_data); end
    do_pop();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ext_single got=%b exp=0", evt_valid); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) send_byte(seq[i]);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL pause_early got=%b exp=0", evt_valid); end
    send_byte(seq[7]);
    total++; if (evt_data !== 10'h2E1) begin bad++; $display("[TB] FAIL pause_evt got=%h exp=2E1", evt_data); end
    do_pop();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL pause_single got=%b exp=0", evt_valid); end
    total++; if (mods !== 4'h0) begin bad++; $display("[TB] FAIL pause_mods got=%h exp=0", mods); end
  endtask

  task automatic test_mods();
    send_byte(8'h12);
    total++; if (mods !== 4'b0001) begin bad++; $display("[TB] FAIL shift_on got=%b exp=0001", mods); end
    send_byte(8'h1C);
    total++; if (mods !== 4'b0001) begin bad++; $display("[TB] FAIL shift_hold got=%b exp=0001", mods); end
    send_byte(8'hF0); send_byte(8'h12);
    total++; if (mods !== 4'b0000) begin bad++; $display("[TB] FAIL shift_off got=%b exp=0000", mods); end
    total++; if (evt_data !== 10'h012) begin bad++; $display("[TB] FAIL mods_ev0 got=%h exp=012", evt_data); end
    do_pop();
    total++; if (evt_data !== 10'h01C) begin bad++; $display("[TB] FAIL mods_ev1 got=%h exp=01C", evt_data); end
    do_pop();
    total++; if (evt_data !== 10'h112) begin bad++; $display("[TB] FAIL mods_ev2 got=%h exp=112", evt_data); end
    flush();
    send_byte(8'h59);
    total++; if (mods !== 4'b0001) begin bad++; $display("[TB] FAIL rshift_on got=%b exp=0001", mods); end
    send_byte(8'hF0); send_byte(8'h59);
    send_byte(8'hE0); send_byte(8'h14);
    total++; if (mods !== 4'b0010) begin bad++; $display("[TB] FAIL rctrl_on got=%b exp=0010", mods); end
    send_byte(8'h11);
    total++; if (mods !== 4'b0110) begin bad++; $display("[TB] FAIL alt_on got=%b exp=0110", mods); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    total++; if (mods !== 4'b0100) begin bad++; $display("[TB] FAIL rctrl_off got=%b exp=0100", mods); end
    send_byte(8'hF0); send_byte(8'h11);
    total++; if (mods !== 4'b0000) begin bad++; $display("[TB] FAIL alt_off got=%b exp=0000", mods); end
    flush();
    send_byte(8'h58);
    total++; if (mods !== 4'b1000) begin bad++; $display("[TB] FAIL caps_on got=%b exp=1000", mods); end
    send_byte(8'h58);
    total++; if (mods !== 4'b1000) begin bad++; $display("[TB] FAIL caps_repeat got=%b exp=1000", mods); end
    send_byte(8'hF0); send_byte(8'h58);
    total++; if (mods !== 4'b1000) begin bad++; $display("[TB] FAIL caps_release got=%b exp=1000", mods); end
    send_byte(8'h58);
    total++; if (mods !== 4'b0000) begin bad++; $display("[TB] FAIL caps_off got=%b exp=0000", mods); end
    send_byte(8'hF0); send_byte(8'h58);
    flush();
  endtask

  task automatic test_timeout();
    send_byte(8'hE0); idle(PT); send_byte(8'h1C);
    total++; if (evt_data !== 10'h01C) begin bad++; $display("[TB] FAIL timeout_plain got=%h exp=01C", evt_data); end
    do_pop();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL timeout_single got=%b exp=0", evt_valid); end
    send_byte(8'hE0); idle(PT - 1); send_byte(8'h75);
    total++; if (evt_data !== 10'h275) begin bad++; $display("[TB] FAIL timeout_edge got=%h exp=275", evt_data); end
    flush();
  endtask

  task automatic test_status();
    send_byte(8'hE0); send_byte(8'hAA);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL status_noevt got=%b exp=0", evt_valid); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("[TB] FAIL status_err1 got=%0d exp=1", err_cnt); end
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'hFA); send_byte(8'h1C);
    total++; if (err_cnt !== 8'd2) begin bad++; $display("[TB] FAIL status_err2 got=%0d exp=2", err_cnt); end
    total++; if (evt_data !== 10'h01C) begin bad++; $display("[TB] FAIL status_abort got=%h exp=01C", evt_data); end
    flush();
    for (int i = 0; i < 260; i++) send_byte(8'hFF);
    total++; if (err_cnt !== 8'd255) begin bad++; $display("[TB] FAIL status_sat got=%0d exp=255", err_cnt); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL status_ff_noevt got=%b exp=0", evt_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) send_byte(codes[i]);
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_full got=%b exp=0", ovf); end
    send_byte(codes[8]);
    total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b exp=1", ovf); end
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clr got=%b exp=0", ovf); end
    ovf_clr = 1'b1; send_byte(8'h4B); ovf_clr = 1'b0;
    total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set_wins got=%b exp=1", ovf); end
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (evt_data !== {2'b00, codes[i]}) begin
        bad++; $display("[TB] FAIL ovf_order[%0d] got=%h exp=%h", i, evt_data, {2'b00, codes[i]});
      end
      do_pop();
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_drained got=%b exp=0", evt_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) send_byte(codes[i]);
    evt_rd = 1'b1; send_byte(8'h4D); evt_rd = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL b2b_no_ovf got=%b exp=0", ovf); end
    for (int i = 1; i < 9; i++) begin
      logic [9:0] exp_v;
      exp_v = (i == 8) ? 10'h04D : {2'b00, codes[i]};
      total++;
      if (evt_data !== exp_v) begin
        bad++; $display("[TB] FAIL b2b_order[%0d] got=%h exp=%h", i, evt_data, exp_v);
      end
      do_pop();
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_count got=%b exp=0", evt_valid); end
    evt_rd = 1'b1; send_byte(8'h4B); evt_rd = 1'b0;
    total++; if (evt_data !== 10'h04B) begin bad++; $display("[TB] FAIL empty_pushpop got=%h exp=04B", evt_data); end
    do_pop();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL empty_pushpop_one got=%b exp=0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h12); send_byte(8'h58); send_byte(8'hE0);
    rst = 1'b1;
    #1;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b exp=0", evt_valid); end
    total++; if (evt_data !== 10'h000) begin bad++; $display("[TB] FAIL rstmid_data got=%h exp=000", evt_data); end
    total++; if (mods !== 4'h0) begin bad++; $display("[TB] FAIL rstmid_mods got=%h exp=0", mods); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_err got=%h exp=00", err_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h75);
    total++; if (evt_data !== 10'h075) begin bad++; $display("[TB] FAIL rstmid_prefix got=%h exp=075", evt_data); end
    flush();
  endtask

  initial begin
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_mods();
    test_timeout();
    test_status();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
